instruction_fetch_unit: RTL and testbench

- Fetch stage directly upstream of the main control decoder. Owns the PC, issues word reads to instruction memory over a variable-latency request/response interface, and presents one instruction at a time with valid/ready to decode.
- Opcode[6:0] is driven straight to the control decoder. Full Instruction and PC go to the register file, immediate generator and branch adder.
- Handles taken-branch redirects, including flushing a response that is already in flight.

---
 rtl/fetch_pkg.sv | 14 +
 rtl/pc_register.sv | 30 +++
 rtl/instruction_fetch_unit.sv | 112 +++++++++++
 tb/tb_instruction_fetch_unit.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and RV base opcodes, also used by the control decoder.
package fetch_pkg;

    typedef enum logic [1:0] {REQ, WAIT, FLUSH, HOLD} fetch_state_t;

    localparam logic [31:0] NOP_INST  = 32'h00000013;

    localparam logic [6:0]  OP_RTYPE  = 7'b0110011;
    localparam logic [6:0]  OP_LOAD   = 7'b0000011;
    localparam logic [6:0]  OP_STORE  = 7'b0100011;
    localparam logic [6:0]  OP_BRANCH = 7'b1100011;
    localparam logic [6:0]  OP_ITYPE  = 7'b0010011;

endpackage

// File: rtl/pc_register.sv
// Program counter: reset load, word-aligned redirect, and sequential +4 advance.
module pc_register #(
    parameter int                  PC_WIDTH = 64,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_inc,
    input  logic                i_redirect,
    input  logic [PC_WIDTH-1:0] i_redirect_pc,
    output logic [PC_WIDTH-1:0] o_pc
);

    localparam logic [PC_WIDTH-1:0] ALIGN_MASK = {{(PC_WIDTH-2){1'b1}}, 2'b00};

    logic [PC_WIDTH-1:0] r_pc;

    // Redirect beats the sequential advance; +4 wraps silently at the top.
    always_ff @(posedge clk) begin
        if (reset)
            r_pc <= RESET_PC;
        else if (i_redirect)
            r_pc <= i_redirect_pc & ALIGN_MASK;
        else if (i_inc)
            r_pc <= r_pc + PC_WIDTH'(4);
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: one outstanding word read to instruction memory, one held
// instruction presented to decode, with branch redirect and stale-response flush.
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                  PC_WIDTH   = 64,
    parameter logic [PC_WIDTH-1:0] RESET_PC   = '0,
    parameter int                  INST_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  IMemReq,
    output logic [PC_WIDTH-1:0]   IMemAddr,
    input  logic                  IMemGnt,
    input  logic                  IMemRspValid,
    input  logic [INST_WIDTH-1:0] IMemRspData,
    input  logic                  Redirect,
    input  logic [PC_WIDTH-1:0]   RedirectPC,
    output logic                  InstValid,
    input  logic                  InstReady,
    output logic [INST_WIDTH-1:0] Instruction,
    output logic [6:0]            Opcode,
    output logic [PC_WIDTH-1:0]   PC_Out
);

    fetch_state_t          r_state;
    logic                  r_pend;
    logic                  r_valid;
    logic [INST_WIDTH-1:0] r_inst;
    logic [PC_WIDTH-1:0]   r_pc_out;

    logic [PC_WIDTH-1:0]   w_pc;
    logic                  w_inc;
    logic                  w_hs;

    assign w_inc = (r_state == WAIT) && IMemRspValid && !Redirect;

    pc_register #(
        .PC_WIDTH (PC_WIDTH),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk           (clk),
        .reset         (reset),
        .i_inc         (w_inc),
        .i_redirect    (Redirect),
        .i_redirect_pc (RedirectPC),
        .o_pc          (w_pc)
    );

    // A request left outstanding across reset blocks new requests until drained.
    assign IMemReq  = (r_state == REQ) && !r_pend && !reset;
    assign IMemAddr = w_pc;
    assign w_hs     = IMemReq && IMemGnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= REQ;
            r_valid  <= 1'b0;
            r_inst   <= INST_WIDTH'(NOP_INST);
            r_pc_out <= '0;
            // Memory is not reset: remember an in-flight request so its reply is dropped.
            r_pend   <= r_pend && !IMemRspValid;
        end else begin
            if (IMemRspValid)
                r_pend <= 1'b0;
            if (w_hs)
                r_pend <= 1'b1;

            case (r_state)
                REQ: begin
                    if (r_pend) begin
                        if (!IMemRspValid)
                            r_state <= FLUSH;
                    end else if (w_hs) begin
                        r_state <= Redirect ? FLUSH : WAIT;
                    end
                end
                WAIT: begin
                    if (IMemRspValid) begin
                        if (Redirect) begin
                            r_state <= REQ;
                        end else begin
                            r_inst   <= IMemRspData;
                            r_pc_out <= w_pc;
                            r_valid  <= 1'b1;
                            r_state  <= HOLD;
                        end
                    end else if (Redirect) begin
                        r_state <= FLUSH;
                    end
                end
                HOLD: begin
                    if (Redirect || InstReady) begin
                        r_valid <= 1'b0;
                        r_state <= REQ;
                    end
                end
                FLUSH: begin
                    if (IMemRspValid)
                        r_state <= REQ;
                end
                default: r_state <= REQ;
            endcase
        end
    end

    assign InstValid   = r_valid;
    assign Instruction = r_inst;
    assign Opcode      = r_inst[6:0];
    assign PC_Out      = r_pc_out;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Randomized bench for instruction_fetch_unit against a fetch-order reference model.
module tb_instruction_fetch_unit;

    localparam int          PW   = 64;
    localparam int          IW   = 32;
    localparam logic [63:0] RPC  = 64'h0;
    localparam logic [31:0] NOP  = 32'h00000013;

    logic          clk = 1'b0;
    logic          reset;
    logic          IMemReq;
    logic [PW-1:0] IMemAddr;
    logic          IMemGnt;
    logic          IMemRspValid;
    logic [IW-1:0] IMemRspData;
    logic          Redirect;
    logic [PW-1:0] RedirectPC;
    logic          InstValid;
    logic          InstReady;
    logic [IW-1:0] Instruction;
    logic [6:0]    Opcode;
    logic [PW-1:0] PC_Out;

    instruction_fetch_unit #(.PC_WIDTH(PW), .RESET_PC(RPC), .INST_WIDTH(IW)) dut (
        .clk          (clk),
        .reset        (reset),
        .IMemReq      (IMemReq),
        .IMemAddr     (IMemAddr),
        .IMemGnt      (IMemGnt),
        .IMemRspValid (IMemRspValid),
        .IMemRspData  (IMemRspData),
        .Redirect     (Redirect),
        .RedirectPC   (RedirectPC),
        .InstValid    (InstValid),
        .InstReady    (InstReady),
        .Instruction  (Instruction),
        .Opcode       (Opcode),
        .PC_Out       (PC_Out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Memory contents are a fixed function of the word address.
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return (a[31:0] * 32'h9E3779B1) ^ a[63:32] ^ 32'h0000_5A13;
    endfunction

    // Reference model: m_pc is the address of the next instruction decode must see.
    logic [63:0] m_pc;
    bit          m_out;
    logic [63:0] m_addr;
    int          m_lat;
    bit          rst_prev, stay_prev;
    logic [31:0] last_inst;
    logic [63:0] last_pc;
    int          ndel;
    bit          hs, dlv;

    initial begin
        reset = 1'b1; IMemGnt = 1'b0; IMemRspValid = 1'b0; IMemRspData = '0;
        Redirect = 1'b0; RedirectPC = '0; InstReady = 1'b0;
        m_pc = RPC; m_out = 1'b0; m_addr = '0; m_lat = 0;
        rst_prev = 1'b0; stay_prev = 1'b0; last_inst = '0; last_pc = '0; ndel = 0;

        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (rst_prev) begin
                chk("rst_valid", 64'(InstValid), 64'd0);
                chk("rst_inst", 64'(Instruction), 64'(NOP));
                chk("rst_pcout", PC_Out, 64'd0);
            end
            if (stay_prev) begin
                chk("hold_valid", 64'(InstValid), 64'd1);
                chk("hold_inst", 64'(Instruction), 64'(last_inst));
                chk("hold_pc", PC_Out, last_pc);
            end

            reset = (c < 2) || ($urandom_range(0, 59) == 0);
            if (m_out && m_lat == 0) begin
                IMemRspValid = 1'b1;
                IMemRspData  = mem_word(m_addr);
            end else begin
                IMemRspValid = 1'b0;
                IMemRspData  = $urandom;
            end
            IMemGnt   = ($urandom_range(0, 3) != 0);
            InstReady = ($urandom_range(0, 3) != 0);
            Redirect  = ($urandom_range(0, 11) == 0);
            case ($urandom_range(0, 4))
                0: RedirectPC = 64'h103;
                1: RedirectPC = 64'hFFFF_FFFF_FFFF_FFFC;
                2: RedirectPC = 64'h100;
                3: RedirectPC = {$urandom, $urandom};
                default: RedirectPC = 64'hFFFF_FFFF_FFFF_FFF9;
            endcase
            #1;

            if (reset)
                chk("req_in_reset", 64'(IMemReq), 64'd0);
            if (IMemReq)
                chk("one_in_flight", 64'(m_out), 64'd0);
            if (InstValid)
                chk("req_in_hold", 64'(IMemReq), 64'd0);

            hs  = IMemReq && IMemGnt;
            dlv = InstValid && InstReady;
            if (hs && !Redirect && !reset)
                chk("req_addr", IMemAddr, m_pc);
            if (dlv && !Redirect && !reset) begin
                chk("dlv_pc", PC_Out, m_pc);
                chk("dlv_inst", 64'(Instruction), 64'(mem_word(m_pc)));
                chk("dlv_opcode", 64'(Opcode), 64'(mem_word(m_pc) & 32'h7F));
                m_pc = m_pc + 64'd4;
                ndel++;
            end
            if (Redirect)
                m_pc = RedirectPC & ~64'd3;
            if (reset)
                m_pc = RPC;

            if (IMemRspValid)
                m_out = 1'b0;
            else if (m_out)
                m_lat--;
            if (hs) begin
                m_out  = 1'b1;
                m_addr = IMemAddr;
                m_lat  = $urandom_range(0, 3);
            end

            rst_prev  = reset;
            stay_prev = InstValid && !InstReady && !Redirect && !reset;
            last_inst = Instruction;
            last_pc   = PC_Out;
        end

        chk("progress", 64'(ndel >= 100), 64'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
